conv2d_layer_sequencer: RTL
===========================

Name: conv2d_layer_sequencer

Overview:
Controller that runs one Conv2D layer pass. On start it loads the KERNEL_SIZE² weight addresses from the weight memory into the Conv2D kernel port. It then streams the F_IN_W×F_IN_H input feature map from the feature memory with a valid/ready handshake. Finally it accepts and counts the F_OUT_W×F_OUT_H output transactions, flagging an error on a timeout or out-of-order addresses. It sits between the layer-level scheduler and one Conv2D instance.

Parameters:
F_IN_W, 29, input feature width
F_IN_H, 13, input feature height
F_OUT_W, 14, output feature width
F_OUT_H, 6, output feature height
KERNEL_SIZE, 3, kernel side; weight word count = KERNEL_SIZE²
KERNEL_WEIGHTS_ADDRWIDE, 12, weight address width
FEATURE_IN_ADDRWIDE, 12, input feature address width
FEATURE_OUT_ADDRWIDE, 12, output address and count width
TIMEOUT_CYCLES, 1024, maximum idle cycles in DRAIN (16-bit counter)

Ports:
clk_i  in  1  clock; single clock domain
rst_i  in  1  synchronous, active-high reset
start_i  in  1  start a pass; sampled only in IDLE
abort_i  in  1  return to IDLE on the next cycle without asserting done_o
busy_o  out  1  high in every state except IDLE
done_o  out  1  one-cycle pulse at pass end
err_o  out  1  sticky error flag; cleared on an accepted start_i
out_count_o  out  FEATURE_OUT_ADDRWIDE  number of outputs accepted this pass
wmem_rd_en_o  out  1  weight memory read enable
wmem_addr_o  out  KERNEL_WEIGHTS_ADDRWIDE  weight memory read address
kernel_weights_valid_o  out  1  to Conv2D kernel_weights_valid_i
kernel_weights_addr_o  out  KERNEL_WEIGHTS_ADDRWIDE  to Conv2D kernel_weights_addr_i
fmem_rd_en_o  out  1  feature memory read enable
fmem_addr_o  out  FEATURE_IN_ADDRWIDE  feature memory read address
feature_in_valid_o  out  1  to Conv2D feature_in_valid_i
feature_in_addr_o  out  FEATURE_IN_ADDRWIDE  to Conv2D feature_in_addr_i
feature_in_ready_i  in  1  from Conv2D feature_in_ready_o
feature_out_valid_i  in  1  Conv2D feature_out_valid_o[0]
feature_out_addr_i  in  FEATURE_OUT_ADDRWIDE  Conv2D feature_out_addr_o
feature_out_ready_o  out  1  to Conv2D feature_out_ready_i

Behaviour:
- Memories: read latency of 1 cycle. Output is held while rd_en is low. Memory data goes straight to Conv2D; this block drives only addresses and control.
- Reset: state=IDLE. All outputs are 0, all counters are 0 and err_o=0. abort_i has the same effect except that err_o and out_count_o are kept.
- Sizes: N_W=KERNEL_SIZE², N_IN=F_IN_W·F_IN_H, N_OUT=F_OUT_W·F_OUT_H.
- States: IDLE, LOAD_W, W_TAIL, STREAM, DRAIN, DONE.
- IDLE:
  - start_i=1 moves to LOAD_W and clears all counters and err_o.
  - start_i in any other state is ignored.
- LOAD_W:
  - wmem_rd_en_o=1 for N_W cycles, wmem_addr_o=0..N_W-1.
  - kernel_weights_valid_o and kernel_weights_addr_o are wmem_rd_en_o and wmem_addr_o registered one cycle.
  - No backpressure. After the address N_W-1 cycle, go to W_TAIL.
- W_TAIL: one cycle in which the last weight is presented, then STREAM.
- STREAM:
  - Let adv = rd_cnt<N_IN && (!feature_in_valid_o || feature_in_ready_i). Then fmem_rd_en_o=adv, fmem_addr_o=rd_cnt, and rd_cnt increments on adv.
  - Next feature_in_valid_o = adv ? 1 : (feature_in_ready_i ? 0 : feature_in_valid_o).
  - feature_in_addr_o loads fmem_addr_o when adv=1.
  - An accept is valid&&ready. The cycle after the N_IN-th accept, go to DRAIN with feature_in_valid_o=0.
  - Valid is never dropped without an accept, and data and address are stable while stalled.
- Output side (STREAM and DRAIN):
  - feature_out_ready_o=1; in every other state it is 0.
  - Each valid&&ready increments out_count_o.
  - If feature_out_addr_i differs from out_count_o (pre-increment), err_o is set. Counting continues.
  - Output accepts beyond N_OUT set err_o and are not counted.
- DRAIN:
  - The idle counter resets on every output accept and otherwise increments.
  - If out_count_o==N_OUT, go to DONE (DRAIN lasts at least 1 cycle).
  - If the idle counter reaches TIMEOUT_CYCLES, set err_o and go to DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE. err_o and out_count_o hold until the next start.
- Simultaneous events:
  - abort_i has priority over every transition.
  - The last output accept in the same cycle as the timeout: count wins, no error.

Test Plan:
- Default parameters, ready always 1, Conv2D emits outputs 0..83 in order:
  - start at cycle 0 gives weight valid in cycles 2..10 with addresses 0..8.
  - fmem addresses 0..376 start at cycle 11, feature_in_valid_o starting at cycle 12.
  - out_count_o reaches 84, then done_o pulses once and err_o=0.
- feature_in_ready_i toggles 1,0,0,1 repeating: every address 0..376 is accepted exactly once in order, and addr/valid stay stable while ready=0.
- Outputs 0..82 only: DRAIN times out after 1024 idle cycles, then done_o and err_o are set with out_count_o=83.
- Out-of-order outputs (address 5 presented at count 4): err_o=1 and the pass still completes with out_count_o=84.
- abort_i during STREAM at rd_cnt=100: the next cycle has state IDLE, busy_o=0, all valids 0 and no done_o. A new start_i re-runs the pass from weight address 0.
- rst_i mid-LOAD_W: the next cycle has all outputs 0. start_i during busy is ignored (no restart, no extra weight load).

Source files
------------

// File: rtl/conv2d_layer_sequencer.sv
// Sequences one Conv2D layer pass: kernel weight load, input feature stream, output collection.
// Only addresses and control are driven here; memory data flows straight into the Conv2D core.
module conv2d_layer_sequencer #(
    parameter int F_IN_W                  = 29,
    parameter int F_IN_H                  = 13,
    parameter int F_OUT_W                 = 14,
    parameter int F_OUT_H                 = 6,
    parameter int KERNEL_SIZE             = 3,
    parameter int KERNEL_WEIGHTS_ADDRWIDE = 12,
    parameter int FEATURE_IN_ADDRWIDE     = 12,
    parameter int FEATURE_OUT_ADDRWIDE    = 12,
    parameter int TIMEOUT_CYCLES          = 1024
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               start_i,
    input  logic                               abort_i,
    output logic                               busy_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic [FEATURE_OUT_ADDRWIDE-1:0]    out_count_o,
    output logic                               wmem_rd_en_o,
    output logic [KERNEL_WEIGHTS_ADDRWIDE-1:0] wmem_addr_o,
    output logic                               kernel_weights_valid_o,
    output logic [KERNEL_WEIGHTS_ADDRWIDE-1:0] kernel_weights_addr_o,
    output logic                               fmem_rd_en_o,
    output logic [FEATURE_IN_ADDRWIDE-1:0]     fmem_addr_o,
    output logic                               feature_in_valid_o,
    output logic [FEATURE_IN_ADDRWIDE-1:0]     feature_in_addr_o,
    input  logic                               feature_in_ready_i,
    input  logic                               feature_out_valid_i,
    input  logic [FEATURE_OUT_ADDRWIDE-1:0]    feature_out_addr_i,
    output logic                               feature_out_ready_o,
    output logic [2:0]                         dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_W_TAIL = 3'd2,
        S_STREAM = 3'd3,
        S_DRAIN  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam int N_W   = KERNEL_SIZE * KERNEL_SIZE;
    localparam int N_IN  = F_IN_W * F_IN_H;
    localparam int N_OUT = F_OUT_W * F_OUT_H;
    localparam int WCW   = KERNEL_WEIGHTS_ADDRWIDE + 1;
    localparam int RCW   = FEATURE_IN_ADDRWIDE + 1;

    localparam logic [WCW-1:0]                  W_LAST    = WCW'(N_W - 1);
    localparam logic [RCW-1:0]                  IN_TOTAL  = RCW'(N_IN);
    localparam logic [RCW-1:0]                  IN_LAST   = RCW'(N_IN - 1);
    localparam logic [FEATURE_OUT_ADDRWIDE-1:0] OUT_TOTAL = FEATURE_OUT_ADDRWIDE'(N_OUT);
    localparam logic [15:0]                     IDLE_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t         state;
    state_t         state_next;
    logic [WCW-1:0] w_cnt;
    logic [RCW-1:0] rd_cnt;
    logic [RCW-1:0] in_cnt;
    logic [15:0]    idle_cnt;

    logic adv;
    logic in_accept;
    logic out_accept;
    logic timeout;

    // Handshake: a transfer happens on a cycle where valid and ready are both high;
    // once raised, valid holds with a stable address until that transfer occurs.
    assign adv        = (state == S_STREAM) && (rd_cnt < IN_TOTAL)
                        && (!feature_in_valid_o || feature_in_ready_i);
    assign in_accept  = feature_in_valid_o && feature_in_ready_i;
    assign out_accept = feature_out_valid_i && feature_out_ready_o;
    // An accept in the final idle cycle resets the counter, so the count always beats the timeout.
    assign timeout    = (state == S_DRAIN) && (out_count_o != OUT_TOTAL)
                        && !out_accept && (idle_cnt == IDLE_LAST);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (start_i) state_next = S_LOAD_W;
            S_LOAD_W: if (w_cnt == W_LAST) state_next = S_W_TAIL;
            S_W_TAIL: state_next = S_STREAM;
            S_STREAM: if (in_accept && (in_cnt == IN_LAST)) state_next = S_DRAIN;
            S_DRAIN:  if ((out_count_o == OUT_TOTAL) || timeout) state_next = S_DONE;
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort_i) state_next = S_IDLE;
    end

    always_comb begin
        busy_o              = (state != S_IDLE);
        done_o              = (state == S_DONE);
        wmem_rd_en_o        = (state == S_LOAD_W);
        wmem_addr_o         = '0;
        fmem_rd_en_o        = adv;
        fmem_addr_o         = '0;
        feature_out_ready_o = (state == S_STREAM) || (state == S_DRAIN);
        dbg_state           = state;
        if (state == S_LOAD_W) wmem_addr_o = w_cnt[KERNEL_WEIGHTS_ADDRWIDE-1:0];
        if (state == S_STREAM) fmem_addr_o = rd_cnt[FEATURE_IN_ADDRWIDE-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            w_cnt                  <= '0;
            rd_cnt                 <= '0;
            in_cnt                 <= '0;
            idle_cnt               <= '0;
            out_count_o            <= '0;
            err_o                  <= 1'b0;
            kernel_weights_valid_o <= 1'b0;
            kernel_weights_addr_o  <= '0;
            feature_in_valid_o     <= 1'b0;
            feature_in_addr_o      <= '0;
        end else if (abort_i) begin
            w_cnt                  <= '0;
            rd_cnt                 <= '0;
            in_cnt                 <= '0;
            idle_cnt               <= '0;
            kernel_weights_valid_o <= 1'b0;
            kernel_weights_addr_o  <= '0;
            feature_in_valid_o     <= 1'b0;
            feature_in_addr_o      <= '0;
        end else begin
            // Memory read latency is one cycle, so the kernel port trails the read by one register.
            kernel_weights_valid_o <= wmem_rd_en_o;
            kernel_weights_addr_o  <= wmem_addr_o;
            if ((state == S_IDLE) && start_i) begin
                w_cnt             <= '0;
                rd_cnt            <= '0;
                in_cnt            <= '0;
                idle_cnt          <= '0;
                out_count_o       <= '0;
                err_o             <= 1'b0;
                feature_in_addr_o <= '0;
            end
            if (state == S_LOAD_W) w_cnt <= w_cnt + 1'b1;
            if (adv) begin
                rd_cnt            <= rd_cnt + 1'b1;
                feature_in_addr_o <= fmem_addr_o;
            end
            if (state == S_STREAM) begin
                feature_in_valid_o <= adv ? 1'b1 : (feature_in_ready_i ? 1'b0 : feature_in_valid_o);
            end
            if (in_accept) in_cnt <= in_cnt + 1'b1;
            if (out_accept) begin
                if (out_count_o == OUT_TOTAL) begin
                    err_o <= 1'b1;
                end else begin
                    if (feature_out_addr_i != out_count_o) err_o <= 1'b1;
                    out_count_o <= out_count_o + 1'b1;
                end
            end
            if (state == S_DRAIN) idle_cnt <= out_accept ? 16'd0 : idle_cnt + 16'd1;
            if (timeout) err_o <= 1'b1;
        end
    end

endmodule
